// File: rtl/act_mem_readout.sv
// Streams a contiguous block of activation-memory words through a 2-entry FIFO to a valid/ready port.
// Optional double-buffer half select is enabled with macro ACT_READOUT_BUFSEL_EN (adds input buf_sel).
module act_mem_readout #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_words,
`ifdef ACT_READOUT_BUFSEL_EN
    input  logic              buf_sel,
`endif
    output logic              busy,
    output logic              done,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ZERO  = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        count_q, count_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [DATA_W-1:0] fifo0_q, fifo0_d;
    logic [DATA_W-1:0] fifo1_q, fifo1_d;

    logic              pop_s;
    logic              push_s;
    logic              mem_req_s;
    logic [2:0]        occ_after_s;
    logic [ADDR_W-1:0] start_addr_s;

`ifdef ACT_READOUT_BUFSEL_EN
    localparam logic [ADDR_W-1:0] HALF_OFFSET = {1'b1, {(ADDR_W-1){1'b0}}};
    assign start_addr_s = buf_sel ? (base_addr + HALF_OFFSET) : base_addr;
`else
    assign start_addr_s = base_addr;
`endif

    // Request gating: a read is only issued if its data is guaranteed a FIFO slot on arrival.
    always_comb begin
        pop_s       = (count_q != 2'd0) && out_ready;
        push_s      = inflight_q;
        occ_after_s = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop_s};
        mem_req_s   = (state_q == RUN) && (remaining_q != CNT_ZERO) && (occ_after_s < 3'd2);
    end

    // Sequencer next-state, address and word-count bookkeeping.
    always_comb begin
        state_d     = state_q;
        done_d      = 1'b0;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        inflight_d  = mem_req_s;
        case (state_q)
            IDLE: begin
                if (start && !busy_q) begin
                    addr_d      = start_addr_s;
                    remaining_d = num_words;
                    if (num_words == CNT_ZERO) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (mem_req_s && (remaining_q == CNT_ONE)) begin
                    state_d = DRAIN;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                // Last word leaves when it is the only one buffered and nothing is still in flight.
                if (pop_s && (count_q == 2'd1) && !inflight_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (mem_req_s) begin
            addr_d      = addr_q + ADDR_ONE;
            remaining_d = remaining_q - CNT_ONE;
        end else begin
            addr_d      = addr_d;
        end
        busy_d = (state_d != IDLE) || done_d;
    end

    // Two-entry FIFO pointer, occupancy and storage update.
    always_comb begin
        fifo0_d  = fifo0_q;
        fifo1_d  = fifo1_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            if (wr_ptr_q) begin
                fifo1_d = mem_rdata;
            end else begin
                fifo0_d = mem_rdata;
            end
            wr_ptr_d = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d = count_q + {1'b0, push_s} - {1'b0, pop_s};
    end

    // State registers; reset drops any buffered or in-flight data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            addr_q      <= {ADDR_W{1'b0}};
            remaining_q <= CNT_ZERO;
            inflight_q  <= 1'b0;
            count_q     <= 2'd0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            fifo0_q     <= {DATA_W{1'b0}};
            fifo1_q     <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            fifo0_q     <= fifo0_d;
            fifo1_q     <= fifo1_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_req   = mem_req_s;
    assign mem_addr  = addr_q;
    assign out_valid = (count_q != 2'd0);
    assign out_data  = rd_ptr_q ? fifo1_q : fifo0_q;

endmodule

// File: tb/tb_act_mem_readout.sv
// Randomized readout bench: a memory array model supplies data, a queue of expected words checks the stream.
module tb_act_mem_readout;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [11:0] base_addr;
    logic [12:0] num_words;
`ifdef ACT_READOUT_BUFSEL_EN
    logic        buf_sel;
`endif
    logic        busy, done, mem_req, out_valid, out_ready;
    logic [11:0] mem_addr;
    logic [31:0] mem_rdata, out_data;

    logic [31:0] memarr [4096];
    logic [31:0] expq [$];
    int n_tests = 0;
    int n_fail  = 0;

    act_mem_readout #(.ADDR_W(12), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_words(num_words),
`ifdef ACT_READOUT_BUFSEL_EN
        .buf_sel(buf_sel),
`endif
        .busy(busy), .done(done), .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // Memory responds one cycle after a request; otherwise the bus carries junk.
    always @(posedge clk) begin
        mem_rdata <= mem_req ? memarr[mem_addr] : $urandom();
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return ((cyc % 4) == 0) || ((cyc % 4) == 3);
        return 1'($urandom_range(0, 1));
    endfunction

    // One readout: mode 0 = ready always high (timing checked), 1 = 1,0,0,1 pattern, 2 = random.
    task automatic run(input int base, input int num, input int bsel, input int mode, input int restart_cyc);
        int eff, issued, accepted, cyc, limit;
        bit done_seen, prev_stall;
        logic [31:0] prev_data;
        eff = (base + bsel * 2048) % 4096;
        expq.delete();
        for (int i = 0; i < num; i++) expq.push_back(memarr[(eff + i) % 4096]);
        issued = 0; accepted = 0; done_seen = 0; prev_stall = 0; prev_data = 0;
        limit = 4 * num + 20;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 12'(base); num_words = 13'(num);
`ifdef ACT_READOUT_BUFSEL_EN
        buf_sel = bsel[0];
`endif
        out_ready = rdy(mode, 0);
        @(negedge clk);
        check("busy_at_start", busy, 1'b0);
        @(posedge clk); #1;
        cyc = 1;
        while (!done_seen && cyc < limit) begin
            start = (cyc == restart_cyc);
            if (cyc == restart_cyc) begin
                base_addr = 12'($urandom_range(0, 4095));
                num_words = 13'(5);
            end
            out_ready = rdy(mode, cyc);
            @(negedge clk);
            check("busy_run", busy, 1'b1);
            if (mem_req) begin
                check("mem_addr", mem_addr, 64'((eff + issued) % 4096));
                issued++;
                check("req_count_le_num", 64'(issued <= num), 64'd1);
            end
            if (mode == 0 && num > 0) begin
                check("req_timing", mem_req, 64'(cyc >= 1 && cyc <= num));
                check("valid_timing", out_valid, 64'(cyc >= 3 && cyc <= num + 2));
            end
            if (prev_stall) check("stall_stable", out_data, prev_data);
            if (out_valid && out_ready) begin
                if (expq.size() > 0) check("out_data", out_data, expq.pop_front());
                else check("extra_word", 64'd1, 64'd0);
                accepted++;
            end
            check("outstanding_le2", 64'((issued - accepted) <= 2), 64'd1);
            if (done) begin
                done_seen = 1;
                check("words_delivered", 64'(accepted), 64'(num));
                if (mode == 0) check("done_cycle", 64'(cyc), 64'(num == 0 ? 1 : num + 3));
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            @(posedge clk); #1;
            cyc++;
        end
        if (!done_seen) check("done_timeout", 64'd0, 64'd1);
        start = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("idle_busy", busy, 1'b0);
            check("idle_done", done, 1'b0);
            check("idle_req", mem_req, 1'b0);
            check("idle_valid", out_valid, 1'b0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) memarr[i] = $urandom();
        reset = 1'b1; start = 1'b0; base_addr = 12'd0; num_words = 13'd0; out_ready = 1'b1;
`ifdef ACT_READOUT_BUFSEL_EN
        buf_sel = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_req", mem_req, 1'b0);
        check("rst_addr", mem_addr, 12'd0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data, 32'd0);
        reset = 1'b0;

        run(12'h010, 4, 0, 0, -1);
        run(12'hFFE, 4, 0, 0, -1);
        run(12'h123, 8, 0, 1, -1);
        run(12'h200, 0, 0, 0, -1);
        run(12'h040, 4, 0, 0, 2);
        run(12'hFFF, 1, 0, 0, -1);

        // Reset while a 6-word readout is part-way through.
        @(posedge clk); #1;
        start = 1'b1; base_addr = 12'h100; num_words = 13'd6; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_w0", out_data, memarr[12'h100]);
        @(negedge clk);
        check("pre_rst_w1", out_data, memarr[12'h101]);
        #1 reset = 1'b1;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_req", mem_req, 1'b0);
        check("arst_addr", mem_addr, 12'd0);
        check("arst_valid", out_valid, 1'b0);
        check("arst_data", out_data, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_rst_valid", out_valid, 1'b0);
            check("post_rst_busy", busy, 1'b0);
        end
        run(12'h020, 1, 0, 0, -1);

`ifdef ACT_READOUT_BUFSEL_EN
        run(12'h004, 2, 1, 0, -1);
        run(12'hFFF, 3, 1, 2, -1);
`endif

        for (int k = 0; k < 10; k++) begin
            run($urandom_range(0, 4095), $urandom_range(0, 24), 0, $urandom_range(0, 2), -1);
        end
        run($urandom_range(0, 4095), 40, 0, 0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
